// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes and FSM state type for the round-robin index arbiter
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search, first set request after ptr (ptr itself last)
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  // scan from lowest to highest priority so the nearest set bit after ptr wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        any = 1'b1;
        idx = ptr + IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: round-robin arbiter offering a binary grant index with valid/ready
module rr_index_arbiter
  import rr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] accept_cnt
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, scan_ptr, pick_idx;
  logic any, accept, load;
  assign out_valid = (state == OFFER);
  assign accept = out_valid & out_ready;
  assign scan_ptr = accept ? out_idx : ptr;
  rr_pick u_pick (
    .req(req),
    .ptr(scan_ptr),
    .any(any),
    .idx(pick_idx)
  );
  // a new grant loads from IDLE or back-to-back on accept; an accept with nothing to pick drops to IDLE
  always_comb begin
    load = (state == IDLE || accept) && en && any;
    state_n = load ? OFFER : (accept ? IDLE : state);
  end
  // state, priority pointer, offered index and accept counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '1;
      out_idx    <= '0;
      accept_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        ptr        <= out_idx;
        accept_cnt <= accept_cnt + 1'b1;
      end
      if (load) out_idx <= pick_idx;
    end
  end
endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb_rr_index_arbiter: scoreboard bench with a behavioural round-robin model
module tb_rr_index_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] req = 8'h00;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [2:0] out_idx;
  logic [7:0] accept_cnt;

  rr_index_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
  } grant_t;

  grant_t sb[$];
  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  int mvalid = 0;
  int midx = 0;
  int mptr = 7;
  int mcnt = 0;
  int exp_valid_now = 0;
  int exp_idx_now = 0;
  int exp_cnt_now = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit rdy);
    int p;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    exp_valid_now = mvalid;
    exp_idx_now = midx;
    exp_cnt_now = mcnt;
    rst_n = r;
    en = e;
    req = q;
    out_ready = r ? rdy : 1'b0;
    p = pick(q, (mvalid != 0 && out_ready) ? midx : mptr);
    if (!r) begin
      mvalid = 0;
      midx = 0;
      mptr = 7;
      mcnt = 0;
      sb.delete();
    end else if (mvalid != 0 && out_ready) begin
      mptr = midx;
      mcnt = (mcnt + 1) % 256;
      if (e && p >= 0) begin
        midx = p;
        sb.push_back('{idx: p, cnt: mcnt});
      end else begin
        mvalid = 0;
      end
    end else if (mvalid == 0 && e && p >= 0) begin
      mvalid = 1;
      midx = p;
      sb.push_back('{idx: p, cnt: mcnt});
    end
  endtask

  // monitor: compares live outputs and retires scoreboard entries on each accept
  always @(negedge clk) begin
    if (mon_on) begin
      check("out_valid", int'(out_valid), exp_valid_now);
      check("accept_cnt", int'(accept_cnt), exp_cnt_now);
      if (out_valid) check("out_idx", int'(out_idx), exp_idx_now);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("accept_without_expected_grant", 1, 0);
        end else begin
          grant_t g;
          g = sb.pop_front();
          check("accepted_idx", int'(out_idx), g.idx);
          check("accepted_cnt", int'(accept_cnt), g.cnt);
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 1);
    check("reset_out_idx", int'(out_idx), 0);
    check("reset_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 8'h81, 1);
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'hFF, 1);
    cyc(1, 1, 8'hFF, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h04, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'h10, 0);
    check("held_idx_two", int'(out_idx), 2);
    cyc(1, 1, 8'h10, 1);
    cyc(1, 1, 8'h10, 0);
    check("next_idx_four", int'(out_idx), 4);
    cyc(1, 0, 8'h10, 1);
    cyc(1, 0, 8'h10, 1);
    cyc(1, 1, 8'h08, 1);
    cyc(1, 1, 8'h08, 0);
    check("idx_three", int'(out_idx), 3);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'h20, 0);
    cyc(1, 1, 8'h20, 0);
    check("offer_five", int'(out_idx), 5);
    cyc(0, 1, 8'h20, 0);
    cyc(1, 1, 8'hFF, 0);
    check("reset_drop_valid", int'(out_valid), 0);
    check("reset_drop_cnt", int'(accept_cnt), 0);
    cyc(1, 1, 8'hFF, 0);
    check("post_reset_idx0", int'(out_idx), 0);
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 257; i++) cyc(1, 1, 8'hFF, 1);
    cyc(1, 1, 8'hFF, 0);
    check("wrap_cnt", int'(accept_cnt), 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, e, rdy;
      logic [7:0] q;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      q = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      cyc(r, e, q, rdy);
    end
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    @(negedge clk);
    check("scoreboard_leftover", sb.size(), mvalid);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
